// File: rtl/add_sub_serial_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: default width and FSM encoding.
package add_sub_serial_pkg;

    localparam int ADD_SUB_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/add_sub_serial_full_adder_cell.sv
// Single-bit full adder; the only arithmetic element of the serial datapath.
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/add_sub_serial.sv
// Bit-serial add/subtract: operands latched on start, summed LSB-first over W cycles,
// result and flags presented in parallel with a one-cycle done pulse.
module add_sub_serial
    import add_sub_serial_pkg::*;
#(
    parameter int W  = ADD_SUB_W,
    parameter int CW = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] res,
    output logic         carry,
    output logic         ovf
);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  opa_q;
    logic [W-1:0]  opb_q;
    logic [W-2:0]  acc_q;
    logic          cin_q;
    logic          busy_q;
    logic          done_q;
    logic [W-1:0]  res_q;
    logic          carry_q;
    logic          ovf_q;

    logic          fa_s;
    logic          fa_co;
    logic [W-1:0]  acc_d;
    logic          last_bit;

    full_adder_cell u_fa (
        .x  (opa_q[0]),
        .y  (opb_q[0]),
        .ci (cin_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // On the last bit acc_d is the complete result; earlier its LSB is discarded.
    assign acc_d    = {fa_s, acc_q};
    assign last_bit = (cnt_q == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            cin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= b ^ {W{sub}};
                        cin_q   <= sub;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d[W-1:1];
                    opa_q <= opa_q >> 1;
                    opb_q <= opb_q >> 1;
                    cin_q <= fa_co;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_bit) begin
                        // cin_q here is the carry into the MSB.
                        res_q   <= acc_d;
                        carry_q <= fa_co;
                        ovf_q   <= cin_q ^ fa_co;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign res   = res_q;
    assign carry = carry_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// Scoreboard bench for add_sub_serial at W=4 and W=8 against a word-level add/sub model.
module tb_add_sub_serial;
    import add_sub_serial_pkg::*;

    logic clk;
    logic rst_n;

    logic       start4, sub4, busy4, done4, carry4, ovf4;
    logic [3:0] a4, b4, res4;
    logic       start8, sub8, busy8, done8, carry8, ovf8;
    logic [7:0] a8, b8, res8;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    logic [5:0] q4[$];   // {ovf, carry, res}
    logic [9:0] q8[$];

    add_sub_serial #(.W(4), .CW(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .sub(sub4),
        .busy(busy4), .done(done4), .res(res4), .carry(carry4), .ovf(ovf4)
    );

    add_sub_serial #(.W(8), .CW(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .sub(sub8),
        .busy(busy8), .done(done8), .res(res8), .carry(carry8), .ovf(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [5:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
        logic [3:0] bb;
        logic [4:0] full;
        logic       v;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {4'b0, s};
        v    = (a[3] == bb[3]) && (full[3] != a[3]);
        return {v, full[4], full[3:0]};
    endfunction

    function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [7:0] bb;
        logic [8:0] full;
        logic       v;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {8'b0, s};
        v    = (a[7] == bb[7]) && (full[7] != a[7]);
        return {v, full[8], full[7:0]};
    endfunction

    always @(negedge clk) begin
        if (rst_n && done4) begin
            compared++;
            assert (q4.size() != 0) else begin
                mismatched++;
                $error("FAIL done4_unexpected: done seen with %0d pending, required >0", q4.size());
            end
            if (q4.size() != 0) begin
                logic [5:0] exp4;
                exp4 = q4.pop_front();
                assert ({ovf4, carry4, res4} === exp4) else begin
                    mismatched++;
                    $error("FAIL result4: got ovf/carry/res=%b, required %b", {ovf4, carry4, res4}, exp4);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done8) begin
            compared++;
            assert (q8.size() != 0) else begin
                mismatched++;
                $error("FAIL done8_unexpected: done seen with %0d pending, required >0", q8.size());
            end
            if (q8.size() != 0) begin
                logic [9:0] exp8;
                exp8 = q8.pop_front();
                assert ({ovf8, carry8, res8} === exp8) else begin
                    mismatched++;
                    $error("FAIL result8: got ovf/carry/res=%b, required %b", {ovf8, carry8, res8}, exp8);
                end
            end
        end
    end

    // Called on a falling edge with the W=4 unit ready; returns on the falling edge where done is seen.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input bit check_lat, input bit disturb);
        int         t0;
        int         nb;
        bit         got;
        logic [3:0] hold;
        a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
        q4.push_back(ref4(a, b, s));
        t0 = cyc;
        hold = res4;
        @(negedge clk);
        start4 = 1'b0;
        nb = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (done4) begin
                got = 1;
            end else begin
                if (busy4) nb++;
                compared++;
                assert (res4 === hold) else begin
                    mismatched++;
                    $error("FAIL res_hold: res changed to %b during run, required %b", res4, hold);
                end
                if (disturb) begin
                    a4 = 4'($urandom); b4 = 4'($urandom); sub4 = 1'($urandom);
                    start4 = ~start4;
                end
                @(negedge clk);
            end
        end
        start4 = 1'b0;
        compared++;
        assert (got) else begin
            mismatched++;
            $error("FAIL done4_timeout: done=%b after 20 cycles, required 1", done4);
        end
        if (check_lat) begin
            compared++;
            assert ((cyc - t0) == 5) else begin
                mismatched++;
                $error("FAIL latency4: done %0d edges after start, required 5", cyc - t0);
            end
            compared++;
            assert (nb == 4 && busy4 === 1'b0) else begin
                mismatched++;
                $error("FAIL busy4: busy cycles=%0d busy_at_done=%b, required 4 and 0", nb, busy4);
            end
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s);
        bit got;
        a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
        q8.push_back(ref8(a, b, s));
        @(negedge clk);
        start8 = 1'b0;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (done8) got = 1;
            else @(negedge clk);
        end
        compared++;
        assert (got) else begin
            mismatched++;
            $error("FAIL done8_timeout: done=%b after 30 cycles, required 1", done8);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        assert ({busy4, done4, res4, carry4, ovf4, busy8, done8, res8, carry8, ovf8} === 20'b0) else begin
            mismatched++;
            $error("FAIL reset_state: got %b/%b, required all zero",
                   {busy4, done4, res4, carry4, ovf4}, {busy8, done8, res8, carry8, ovf8});
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed adds, subtracts and overflow corners
        run4(4'b0011, 4'b0011, 1'b0, 1, 0);
        run4(4'b1010, 4'b0011, 1'b0, 1, 0);
        run4(4'b1111, 4'b0101, 1'b0, 1, 0);
        run4(4'b1100, 4'b1001, 1'b1, 1, 0);
        run4(4'b1100, 4'b1110, 1'b1, 1, 0);
        run4(4'b0111, 4'b0001, 1'b0, 1, 0);
        run4(4'b1000, 4'b0001, 1'b1, 1, 0);

        // Inputs and start wiggled during the run; then idle to catch stray done
        run4(4'b0101, 4'b0110, 1'b0, 1, 1);
        repeat (8) @(negedge clk);

        // Back-to-back: second start on the done cycle
        run4(4'b0010, 4'b0111, 1'b1, 1, 0);
        run4(4'b1001, 4'b1001, 1'b0, 1, 0);
        repeat (2) @(negedge clk);

        // Asynchronous reset two bits into an operation
        a4 = 4'b1010; b4 = 4'b0011; sub4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        assert ({busy4, done4, res4, carry4, ovf4} === 8'b0) else begin
            mismatched++;
            $error("FAIL async_reset: got busy/done/res/carry/ovf=%b, required 00000000",
                   {busy4, done4, res4, carry4, ovf4});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run4(4'b1010, 4'b0011, 1'b0, 1, 0);

        for (int i = 0; i < 1000; i++)
            run4(4'($urandom), 4'($urandom), 1'($urandom), 0, 0);

        run8(8'h7f, 8'h01, 1'b0);
        run8(8'h80, 8'h01, 1'b1);
        for (int i = 0; i < 1000; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom));

        repeat (3) @(negedge clk);
        compared++;
        assert (q4.size() == 0 && q8.size() == 0) else begin
            mismatched++;
            $error("FAIL drain: pending results %0d/%0d, required 0/0", q4.size(), q8.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
